wb_commit_stage: RTL and testbench
==================================

Name: wb_commit_stage

Overview:
- Writeback end of the register-file interface: the producer of writeData / writeRegister / writeEn consumed by the decode stage's register file.
- Accepts retiring instructions from the memory stage over a valid/ready handshake and waits for multi-cycle data-memory read responses on loads.
- Selects the writeback value, commits exactly one register write per instruction, exposes forwarding/pending-load status to hazard logic, and handles HALT (dump) and memory errors.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in WAIT_MEM before a timeout error (range 1..255)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  block can accept this cycle
in_regWrite  input  1  instruction writes a register
in_writeReg  input  3  destination register
in_aluResult  input  16  ALU result
in_memToReg  input  1  load; value comes from data memory
in_link  input  1  JAL/JALR; value is in_pcPlus2
in_pcPlus2  input  16  PC+2 of instruction
in_halt  input  1  HALT instruction
mem_done  input  1  data-memory read response valid
mem_rdData  input  16  read data, valid with mem_done
mem_err  input  1  memory error, sampled with mem_done
writeEn  output  1  register-file write enable
writeRegister  output  3  register-file write select
writeData  output  16  register-file write data
fwd_pending  output  1  load in WAIT_MEM targets fwd_reg (hazard must stall)
fwd_reg  output  3  destination of held instruction
dump  output  1  one-cycle pulse when HALT commits
err  output  1  sticky error flag

Behaviour:
- Reset (rst=1 at edge): state IDLE, latched fields 0, wait counter 0; outputs writeEn=0, writeRegister=0, writeData=0, fwd_pending=0, fwd_reg=0, dump=0, err=0. Reset during WAIT_MEM abandons the load; no write occurs.
- Reset has priority over all other inputs.
- States: IDLE, WAIT_MEM, COMMIT, HALTED.
- in_ready = 1 in IDLE and COMMIT; 0 in WAIT_MEM and HALTED.
- Accept occurs when in_valid && in_ready; all in_* fields are latched on that edge.
  - Next state WAIT_MEM if in_memToReg=1, else COMMIT.
  - With no accept, COMMIT returns to IDLE.
- WAIT_MEM:
  - The wait counter increments each cycle.
  - mem_done=1: latch mem_rdData and go to COMMIT. If mem_err=1 at the same time, set err and go to HALTED with no write.
  - Counter reaches MEM_TIMEOUT without mem_done: set err and go to HALTED.
  - mem_done outside WAIT_MEM is ignored.
- COMMIT, for exactly one cycle:
  - writeEn = latched regWrite; writeRegister = latched reg.
  - writeData priority: link → pcPlus2; memToReg → captured read data; else aluResult.
  - A new instruction may be accepted in the same cycle, giving back-to-back throughput of 1/cycle for non-loads.
- HALT: in its COMMIT cycle, dump=1 (any regWrite is still honoured). Next state HALTED regardless of in_valid; in_ready is forced to 0 in that COMMIT cycle.
- HALTED: no writes, dump=0, remains until rst.
- Latency:
  - Non-load accepted at edge N → writeEn high during cycle N+1.
  - Load: mem_done sampled at edge M → writeEn high during cycle M+1.
- Outputs writeEn/writeRegister/writeData/dump decode from registered state and latched fields only; no combinational path from in_* or mem_*.
- fwd_pending = (state==WAIT_MEM) && latched regWrite. fwd_reg = latched reg whenever state is WAIT_MEM or COMMIT, else 0.
- R0 is an ordinary register: no special-casing of writeRegister=0.
- err is sticky until rst.

Optional Feature:
Macro: WB_PERF_CNT_EN
- Defined: adds output retired_cnt (16) and output load_wait_cnt (16).
  - retired_cnt increments on every COMMIT cycle, HALT included.
  - load_wait_cnt increments on every WAIT_MEM cycle.
  - Both wrap at 16'hFFFF → 0, reset to 0, and freeze in HALTED.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- ALU op: accept regWrite=1, reg=3, aluResult=16'h1234 at edge N → cycle N+1: writeEn=1, writeRegister=3, writeData=16'h1234; cycle N+2: writeEn=0, state IDLE.
- Load: accept memToReg=1, reg=5; mem_done with 16'hBEEF arrives 3 cycles later → fwd_pending=1 and fwd_reg=5 for those 3 cycles, in_ready=0; then one cycle writeEn=1, writeData=16'hBEEF.
- Back-to-back: four non-load instructions on consecutive cycles with in_valid held high → in_ready stays 1; four consecutive writeEn pulses carrying the correct reg/data in order.
- JAL link: in_link=1, in_pcPlus2=16'h0042, aluResult=16'hFFFF, reg=7 → writeData=16'h0042 to R7.
- HALT/error:
  - HALT accepted → dump=1 for exactly one cycle, then in_ready=0 and no further writes with in_valid held high.
  - Load with no mem_done for MEM_TIMEOUT=15 cycles → err=1, no write, HALTED.
  - Load with mem_done=1 and mem_err=1 → err=1, no write, HALTED.
- Reset mid-load: rst=1 during WAIT_MEM, then mem_done pulses → no writeEn, all outputs 0, in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/wb_commit_stage_if.sv
// wb_commit_stage_if: memory-stage handshake, data-memory response and register-file write bundle.
// Perf counter signals exist only when WB_PERF_CNT_EN is defined.
interface wb_commit_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_regWrite;
    logic [2:0]  in_writeReg;
    logic [15:0] in_aluResult;
    logic        in_memToReg;
    logic        in_link;
    logic [15:0] in_pcPlus2;
    logic        in_halt;
    logic        mem_done;
    logic [15:0] mem_rdData;
    logic        mem_err;
    logic        writeEn;
    logic [2:0]  writeRegister;
    logic [15:0] writeData;
    logic        fwd_pending;
    logic [2:0]  fwd_reg;
    logic        dump;
    logic        err;
`ifdef WB_PERF_CNT_EN
    logic [15:0] retired_cnt;
    logic [15:0] load_wait_cnt;
`endif

    modport master (
        output in_valid, in_regWrite, in_writeReg, in_aluResult, in_memToReg,
        output in_link, in_pcPlus2, in_halt, mem_done, mem_rdData, mem_err,
`ifdef WB_PERF_CNT_EN
        input  retired_cnt, load_wait_cnt,
`endif
        input  in_ready, writeEn, writeRegister, writeData, fwd_pending, fwd_reg, dump, err
    );

    modport slave (
        input  in_valid, in_regWrite, in_writeReg, in_aluResult, in_memToReg,
        input  in_link, in_pcPlus2, in_halt, mem_done, mem_rdData, mem_err,
`ifdef WB_PERF_CNT_EN
        output retired_cnt, load_wait_cnt,
`endif
        output in_ready, writeEn, writeRegister, writeData, fwd_pending, fwd_reg, dump, err
    );
endinterface

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: writeback stage committing one register write per retired instruction.
// Optional WB_PERF_CNT_EN adds retired/load-wait counters.
module wb_commit_stage #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    wb_commit_stage_if.slave  bus
);
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT, HALTED} state_e;

    state_e      state_q, state_d;
    logic        rw_q, rw_d;
    logic [2:0]  reg_q, reg_d;
    logic [15:0] alu_q, alu_d;
    logic        mem_q, mem_d;
    logic        link_q, link_d;
    logic [15:0] pc_q, pc_d;
    logic        halt_q, halt_d;
    logic [15:0] rd_q, rd_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic        accept;
    logic        commit;
    logic        waiting;

    assign commit  = state_q == COMMIT;
    assign waiting = state_q == WAIT_MEM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            reg_q   <= 3'd0;
            alu_q   <= 16'd0;
            mem_q   <= 1'b0;
            link_q  <= 1'b0;
            pc_q    <= 16'd0;
            halt_q  <= 1'b0;
            rd_q    <= 16'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            reg_q   <= reg_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            link_q  <= link_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            rd_q    <= rd_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        reg_d   = reg_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        link_d  = link_q;
        pc_d    = pc_q;
        halt_d  = halt_q;
        rd_d    = rd_q;
        wait_d  = wait_q;
        err_d   = err_q;
        // a committing HALT refuses new work so nothing slips in behind it
        bus.in_ready = (state_q == IDLE) || (commit && !halt_q);
        accept = bus.in_valid && bus.in_ready;
        if (accept) begin
            rw_d    = bus.in_regWrite;
            reg_d   = bus.in_writeReg;
            alu_d   = bus.in_aluResult;
            mem_d   = bus.in_memToReg;
            link_d  = bus.in_link;
            pc_d    = bus.in_pcPlus2;
            halt_d  = bus.in_halt;
            wait_d  = 8'd0;
            state_d = bus.in_memToReg ? WAIT_MEM : COMMIT;
        end else if (commit) begin
            state_d = halt_q ? HALTED : IDLE;
        end
        if (waiting) begin
            wait_d = wait_q + 8'd1;
            if (bus.mem_done) begin
                rd_d    = bus.mem_rdData;
                err_d   = err_q || bus.mem_err;
                state_d = bus.mem_err ? HALTED : COMMIT;
            end else if (wait_d == TMO) begin
                err_d   = 1'b1;
                state_d = HALTED;
            end
        end
    end

    assign bus.writeEn       = commit && rw_q;
    assign bus.writeRegister = commit ? reg_q : 3'd0;
    assign bus.writeData     = !commit ? 16'd0 : link_q ? pc_q : mem_q ? rd_q : alu_q;
    assign bus.dump          = commit && halt_q;
    assign bus.err           = err_q;
    assign bus.fwd_pending   = waiting && rw_q;
    assign bus.fwd_reg       = (waiting || commit) ? reg_q : 3'd0;

`ifdef WB_PERF_CNT_EN
    logic [15:0] ret_q;
    logic [15:0] lw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_q <= 16'd0;
            lw_q  <= 16'd0;
        end else begin
            ret_q <= commit ? ret_q + 16'd1 : ret_q;
            lw_q  <= waiting ? lw_q + 16'd1 : lw_q;
        end
    end

    assign bus.retired_cnt   = ret_q;
    assign bus.load_wait_cnt = lw_q;
`endif
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage: directed plan scenarios plus random traffic against a transaction-level model.
module tb_wb_commit_stage;
    typedef struct packed {
        logic        rw;
        logic [2:0]  rg;
        logic [15:0] alu;
        logic        mr;
        logic        lk;
        logic [15:0] pc;
        logic        hl;
    } ins_t;

    logic clk = 1'b0;
    logic rst;
    wb_commit_stage_if bus();

    wb_commit_stage #(.MEM_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus for the next edge
    bit          r, v, md, me;
    ins_t        s;
    logic [15:0] mrd;

    // model: the held instruction, whether its load data has arrived, and global flags
    ins_t        h;
    bit          have, got, halted, m_err;
    logic [15:0] m_rd, m_ret, m_lw;
    int          waited;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        r = 0; v = 0; md = 0; me = 0; mrd = '0; s = '0;
    endtask

    task automatic tick();
        bit com, wt, rdy;
        rst = r;
        bus.in_valid = v;     bus.in_regWrite = s.rw; bus.in_writeReg = s.rg;
        bus.in_aluResult = s.alu; bus.in_memToReg = s.mr; bus.in_link = s.lk;
        bus.in_pcPlus2 = s.pc; bus.in_halt = s.hl;
        bus.mem_done = md;    bus.mem_rdData = mrd;   bus.mem_err = me;
        com = have && (!h.mr || got);
        wt  = have && h.mr && !got;
        if (r) begin
            have = 0; got = 0; halted = 0; m_err = 0; waited = 0;
            m_rd = '0; m_ret = '0; m_lw = '0;
        end else if (!halted) begin
            if (com) m_ret = m_ret + 16'd1;
            if (wt) m_lw = m_lw + 16'd1;
            if (wt) begin
                if (md) begin
                    if (me) begin m_err = 1; halted = 1; have = 0; end
                    else begin m_rd = mrd; got = 1; end
                end else begin
                    waited++;
                    if (waited == 15) begin m_err = 1; halted = 1; have = 0; end
                end
            end else if (com && h.hl) begin
                halted = 1; have = 0;
            end else if (v) begin
                h = s; have = 1; got = 0; waited = 0;
            end else begin
                have = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        com = have && (!h.mr || got);
        wt  = have && h.mr && !got;
        rdy = !halted && !wt && !(com && h.hl);
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        check("writeEn", 32'(bus.writeEn), 32'(com && h.rw));
        check("writeRegister", 32'(bus.writeRegister), com ? 32'(h.rg) : 0);
        check("writeData", 32'(bus.writeData), !com ? 0 : h.lk ? 32'(h.pc) : h.mr ? 32'(m_rd) : 32'(h.alu));
        check("fwd_pending", 32'(bus.fwd_pending), 32'(wt && h.rw));
        check("fwd_reg", 32'(bus.fwd_reg), have ? 32'(h.rg) : 0);
        check("dump", 32'(bus.dump), 32'(com && h.hl));
        check("err", 32'(bus.err), 32'(m_err));
`ifdef WB_PERF_CNT_EN
        check("retired_cnt", 32'(bus.retired_cnt), 32'(m_ret));
        check("load_wait_cnt", 32'(bus.load_wait_cnt), 32'(m_lw));
`endif
    endtask

    task automatic do_reset();
        quiet(); r = 1; tick(); r = 0;
    endtask

    task automatic rand_ins();
        s.rw  = $urandom_range(0, 3) != 0;
        s.rg  = 3'($urandom_range(0, 7));
        s.alu = 16'($urandom);
        s.mr  = $urandom_range(0, 2) == 0;
        s.lk  = $urandom_range(0, 5) == 0;
        s.pc  = 16'($urandom);
        s.hl  = $urandom_range(0, 40) == 0;
    endtask

    initial begin
        logic [15:0] bd [4];
        do_reset();
        check("rst_ready", 32'(bus.in_ready), 1);
        check("rst_we", 32'(bus.writeEn), 0);
        check("rst_err", 32'(bus.err), 0);

        // ALU op
        v = 1; s.rw = 1; s.rg = 3; s.alu = 16'h1234; tick();
        check("alu_we", 32'(bus.writeEn), 1);
        check("alu_reg", 32'(bus.writeRegister), 3);
        check("alu_data", 32'(bus.writeData), 32'h1234);
        quiet(); tick();
        check("alu_we_off", 32'(bus.writeEn), 0);

        // load, response three cycles later
        v = 1; s.rw = 1; s.rg = 5; s.mr = 1; tick();
        quiet();
        for (int i = 0; i < 3; i++) begin
            check("ld_fwdp", 32'(bus.fwd_pending), 1);
            check("ld_fwdr", 32'(bus.fwd_reg), 5);
            check("ld_ready", 32'(bus.in_ready), 0);
            md = (i == 2); mrd = 16'hBEEF; tick();
        end
        check("ld_we", 32'(bus.writeEn), 1);
        check("ld_data", 32'(bus.writeData), 32'hBEEF);
        quiet(); tick();

        // back-to-back non-loads
        for (int i = 0; i < 4; i++) begin
            v = 1; s = '0; s.rw = 1; s.rg = 3'(i + 1); s.alu = 16'($urandom); bd[i] = s.alu;
            tick();
            check("b2b_we", 32'(bus.writeEn), 1);
            check("b2b_reg", 32'(bus.writeRegister), 32'(i + 1));
            check("b2b_data", 32'(bus.writeData), 32'(bd[i]));
            check("b2b_ready", 32'(bus.in_ready), 1);
        end
        quiet(); tick();

        // JAL link
        v = 1; s.rw = 1; s.rg = 7; s.lk = 1; s.pc = 16'h0042; s.alu = 16'hFFFF; tick();
        check("jal_reg", 32'(bus.writeRegister), 7);
        check("jal_data", 32'(bus.writeData), 32'h0042);
        quiet(); tick();

        // HALT with in_valid held high afterwards
        v = 1; s.hl = 1; s.rw = 1; s.rg = 2; s.alu = 16'h0BAD; tick();
        check("halt_dump", 32'(bus.dump), 1);
        check("halt_we", 32'(bus.writeEn), 1);
        check("halt_ready", 32'(bus.in_ready), 0);
        s.hl = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted_dump", 32'(bus.dump), 0);
            check("halted_we", 32'(bus.writeEn), 0);
            check("halted_ready", 32'(bus.in_ready), 0);
        end

        // load timeout
        do_reset();
        v = 1; s.rw = 1; s.rg = 4; s.mr = 1; tick();
        quiet();
        for (int i = 0; i < 14; i++) tick();
        check("tmo_err_before", 32'(bus.err), 0);
        check("tmo_fwdp_before", 32'(bus.fwd_pending), 1);
        tick();
        check("tmo_err", 32'(bus.err), 1);
        check("tmo_ready", 32'(bus.in_ready), 0);
        check("tmo_we", 32'(bus.writeEn), 0);

        // memory error
        do_reset();
        v = 1; s.rw = 1; s.rg = 6; s.mr = 1; tick();
        quiet(); md = 1; me = 1; mrd = 16'h5555; tick();
        check("merr_err", 32'(bus.err), 1);
        check("merr_we", 32'(bus.writeEn), 0);
        quiet(); tick();
        check("merr_we2", 32'(bus.writeEn), 0);
        check("merr_ready", 32'(bus.in_ready), 0);

        // reset mid-load
        do_reset();
        v = 1; s.rw = 1; s.rg = 1; s.mr = 1; tick();
        quiet(); tick();
        r = 1; tick();
        check("rml_ready", 32'(bus.in_ready), 1);
        quiet(); md = 1; mrd = 16'hBEEF; tick();
        check("rml_we", 32'(bus.writeEn), 0);
        check("rml_data", 32'(bus.writeData), 0);
        check("rml_fwdp", 32'(bus.fwd_pending), 0);
        check("rml_ready2", 32'(bus.in_ready), 1);

        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            v = $urandom_range(0, 2) != 0;
            rand_ins();
            md  = $urandom_range(0, 3) == 0;
            me  = md && ($urandom_range(0, 15) == 0);
            mrd = 16'($urandom);
            r   = (halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 200) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
